// File: rtl/risc_v_pkg.sv
// +--------------------------------------------------------------------+
// | risc_v_pkg : shared RV32I opcodes, class/immediate-format enums     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package risc_v_pkg;

  localparam int c_XLEN_DEF = 32;
  localparam int c_NREG_DEF = 32;
  localparam int c_AW_DEF   = 5;

  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    CLS_OP      = 4'd0,
    CLS_OP_IMM  = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_JAL     = 4'd5,
    CLS_JALR    = 4'd6,
    CLS_LUI     = 4'd7,
    CLS_AUIPC   = 4'd8,
    CLS_ILLEGAL = 4'd15
  } cls_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

endpackage

`default_nettype wire

// File: rtl/risc_v_scoreboard.sv
// +--------------------------------------------------------------------+
// | risc_v_scoreboard : pending-destination bit array, two lookups     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module risc_v_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr_a_en,
  input  logic [AW-1:0] i_clr_a_idx,
  input  logic          i_clr_b_en,
  input  logic [AW-1:0] i_clr_b_idx,
  input  logic          i_set_en,
  input  logic [AW-1:0] i_set_idx,
  input  logic [AW-1:0] i_look1_idx,
  input  logic [AW-1:0] i_look2_idx,
  output logic          o_busy1,
  output logic          o_busy2
);

  logic [NREG-1:0] r_sb;
  logic [NREG-1:0] w_next;

  // Clears are applied before the set so a same-cycle reissue keeps the bit.
  always_comb begin
    w_next = r_sb;
    if (i_clr_a_en) w_next[i_clr_a_idx] = 1'b0;
    if (i_clr_b_en) w_next[i_clr_b_idx] = 1'b0;
    if (i_set_en)   w_next[i_set_idx]   = 1'b1;
    w_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sb <= '0;
    else        r_sb <= w_next;
  end

  assign o_busy1 = r_sb[i_look1_idx];
  assign o_busy2 = r_sb[i_look2_idx];

endmodule

`default_nettype wire

// File: rtl/risc_v_decode.sv
// +--------------------------------------------------------------------+
// | risc_v_decode : RV32I decode/issue with RAW scoreboard stalling     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module risc_v_decode
  import risc_v_pkg::*;
#(
  parameter int XLEN = c_XLEN_DEF,
  parameter int NREG = c_NREG_DEF,
  parameter int AW   = c_AW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [XLEN-1:0] i_in_instr,
  input  logic [XLEN-1:0] i_in_pc,
  output logic            o_re1,
  output logic [AW-1:0]   o_raddr1,
  output logic            o_re2,
  output logic [AW-1:0]   o_raddr2,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_out_pc,
  output logic [AW-1:0]   o_out_rd,
  output logic            o_out_rd_we,
  output logic [XLEN-1:0] o_out_imm,
  output logic [3:0]      o_out_cls,
  output logic [3:0]      o_out_funct,
  output logic            o_out_illegal,
  input  logic            i_wb_valid,
  input  logic [AW-1:0]   i_wb_rd,
  input  logic            i_flush
);

  logic [6:0]      w_opcode;
  logic [AW-1:0]   w_rd;
  logic [AW-1:0]   w_rs1;
  logic [AW-1:0]   w_rs2;
  cls_e            w_cls;
  imm_fmt_e        w_fmt;
  logic            w_use1;
  logic            w_use2;
  logic            w_wr;
  logic            w_rd_we;
  logic [XLEN-1:0] w_imm;
  logic            w_busy1;
  logic            w_busy2;
  logic            w_hazard;
  logic            w_can_accept;
  logic            w_issue;

  logic            r_out_valid;
  logic [XLEN-1:0] r_out_pc;
  logic [AW-1:0]   r_out_rd;
  logic            r_out_rd_we;
  logic [XLEN-1:0] r_out_imm;
  cls_e            r_out_cls;
  logic [3:0]      r_out_funct;
  logic            r_out_illegal;

  assign w_opcode = i_in_instr[6:0];
  assign w_rd     = i_in_instr[11:7];
  assign w_rs1    = i_in_instr[19:15];
  assign w_rs2    = i_in_instr[24:20];

  always_comb begin
    w_cls  = CLS_ILLEGAL;
    w_fmt  = IMM_NONE;
    w_use1 = 1'b0;
    w_use2 = 1'b0;
    w_wr   = 1'b0;
    if (i_in_instr[1:0] == 2'b11) begin
      case (w_opcode)
        c_OPC_OP:     begin w_cls = CLS_OP;     w_use1 = 1'b1; w_use2 = 1'b1; w_wr = 1'b1; end
        c_OPC_OP_IMM: begin w_cls = CLS_OP_IMM; w_fmt = IMM_I; w_use1 = 1'b1; w_wr = 1'b1; end
        c_OPC_LOAD:   begin w_cls = CLS_LOAD;   w_fmt = IMM_I; w_use1 = 1'b1; w_wr = 1'b1; end
        c_OPC_STORE:  begin w_cls = CLS_STORE;  w_fmt = IMM_S; w_use1 = 1'b1; w_use2 = 1'b1; end
        c_OPC_BRANCH: begin w_cls = CLS_BRANCH; w_fmt = IMM_B; w_use1 = 1'b1; w_use2 = 1'b1; end
        c_OPC_JAL:    begin w_cls = CLS_JAL;    w_fmt = IMM_J; w_wr = 1'b1; end
        c_OPC_JALR:   begin w_cls = CLS_JALR;   w_fmt = IMM_I; w_use1 = 1'b1; w_wr = 1'b1; end
        c_OPC_LUI:    begin w_cls = CLS_LUI;    w_fmt = IMM_U; w_wr = 1'b1; end
        c_OPC_AUIPC:  begin w_cls = CLS_AUIPC;  w_fmt = IMM_U; w_wr = 1'b1; end
        default:      w_cls = CLS_ILLEGAL;
      endcase
    end
  end

  always_comb begin
    w_imm = '0;
    case (w_fmt)
      IMM_I: w_imm = {{(XLEN-12){i_in_instr[31]}}, i_in_instr[31:20]};
      IMM_S: w_imm = {{(XLEN-12){i_in_instr[31]}}, i_in_instr[31:25], i_in_instr[11:7]};
      IMM_B: w_imm = {{(XLEN-13){i_in_instr[31]}}, i_in_instr[31], i_in_instr[7],
                      i_in_instr[30:25], i_in_instr[11:8], 1'b0};
      IMM_U: w_imm = {i_in_instr[31:12], 12'b0};
      IMM_J: w_imm = {{(XLEN-21){i_in_instr[31]}}, i_in_instr[31], i_in_instr[19:12],
                      i_in_instr[20], i_in_instr[30:21], 1'b0};
      default: w_imm = '0;
    endcase
  end

  assign w_rd_we  = w_wr && (w_rd != '0);
  assign w_hazard = (w_use1 && w_busy1) || (w_use2 && w_busy2);

  // Gated by reset so the RF sees no reads while reset is held.
  assign w_can_accept = rst_n && !w_hazard && !i_flush && (!r_out_valid || i_out_ready);
  assign w_issue      = i_in_valid && w_can_accept;

  assign o_in_ready = w_can_accept;
  assign o_re1      = w_issue && w_use1;
  assign o_re2      = w_issue && w_use2;
  assign o_raddr1   = (rst_n && w_use1) ? w_rs1 : '0;
  assign o_raddr2   = (rst_n && w_use2) ? w_rs2 : '0;

  risc_v_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr_a_en  (i_wb_valid),
    .i_clr_a_idx (i_wb_rd),
    .i_clr_b_en  (i_flush && r_out_valid && r_out_rd_we),
    .i_clr_b_idx (r_out_rd),
    .i_set_en    (w_issue && w_rd_we),
    .i_set_idx   (w_rd),
    .i_look1_idx (w_rs1),
    .i_look2_idx (w_rs2),
    .o_busy1     (w_busy1),
    .o_busy2     (w_busy2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_out_pc      <= '0;
      r_out_rd      <= '0;
      r_out_rd_we   <= 1'b0;
      r_out_imm     <= '0;
      r_out_cls     <= CLS_OP;
      r_out_funct   <= '0;
      r_out_illegal <= 1'b0;
    end else if (i_flush) begin
      r_out_valid <= 1'b0;
    end else if (w_issue) begin
      r_out_valid   <= 1'b1;
      r_out_pc      <= i_in_pc;
      r_out_rd      <= w_rd;
      r_out_rd_we   <= w_rd_we;
      r_out_imm     <= w_imm;
      r_out_cls     <= w_cls;
      r_out_funct   <= {i_in_instr[30], i_in_instr[14:12]};
      r_out_illegal <= (w_cls == CLS_ILLEGAL);
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_out_valid   = r_out_valid;
  assign o_out_pc      = r_out_pc;
  assign o_out_rd      = r_out_rd;
  assign o_out_rd_we   = r_out_rd_we;
  assign o_out_imm     = r_out_imm;
  assign o_out_cls     = r_out_cls;
  assign o_out_funct   = r_out_funct;
  assign o_out_illegal = r_out_illegal;

endmodule

`default_nettype wire
